// File: rtl/axi4_read_responder.sv
// axi4_read_responder
// Memory-side responder for the AXI4-lite read channel pair (AR/R).
// Accepts one read address at a time, waits a programmable number of cycles,
// then returns one 64-bit word from an internal word-organised RAM with an
// OKAY or SLVERR response. A separate preload port fills the RAM.
//
// Optional feature macro: AXI4_RESP_LFSR_DELAY_EN
//   Defined   : each transaction gets 0..7 extra latency cycles taken from a
//               16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that
//               advances once per AR handshake.
//   Undefined : latency is exactly LATENCY for every transaction.

module axi4_read_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          MEM_DEPTH = 1024,
    parameter int          LATENCY   = 2    // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,

    // AR channel
    input  logic        arvalid,
    output logic        arready,
    input  logic [63:0] araddr,

    // R channel
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,

    // Preload port
    input  logic        init_we,
    input  logic [63:0] init_addr,
    input  logic [63:0] init_data
);

    localparam int          IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [63:0] MEM_BYTES  = 64'(MEM_DEPTH) * 64'd8;
    localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + MEM_BYTES;
    // Wide enough for LATENCY-1 (max 14) plus 7 extra LFSR cycles.
    localparam int          CNT_W      = 5;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------

    // An address below BASE_ADDR is rejected by the explicit lower compare;
    // the subtraction in word_index is never trusted to flag it.
    function automatic logic addr_in_range(input logic [63:0] a);
        return (a >= BASE_ADDR) && (a < LIMIT_ADDR);
    endfunction

    // Byte offset from BASE_ADDR, aligned down to a 64-bit word.
    function automatic logic [IDX_W-1:0] word_index(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------

    logic [63:0]      mem [MEM_DEPTH];

    state_t           state_q,   state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q,  rvalid_d;
    logic [63:0]      rdata_q,   rdata_d;
    logic [1:0]       rresp_q,   rresp_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [63:0]      addr_q,    addr_d;

    logic             ar_hs;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;
    logic             init_ok;
    logic [IDX_W-1:0] init_idx;
    logic             init_hits_rd;
    logic [63:0]      rd_word;
    logic [2:0]       extra_lat;
    logic [CNT_W-1:0] cnt_load;

    assign ar_hs    = arvalid && arready_q;

    assign rd_ok    = addr_in_range(addr_q);
    assign rd_idx   = word_index(addr_q);
    assign init_ok  = addr_in_range(init_addr);
    assign init_idx = word_index(init_addr);

    // A preload write landing on the same edge that captures rdata must win,
    // so it is forwarded around the RAM rather than read back a cycle late.
    assign init_hits_rd = init_we && init_ok && (init_idx == rd_idx);
    assign rd_word      = init_hits_rd ? init_data : mem[rd_idx];

    // ------------------------------------------------------------------
    // Optional per-transaction latency jitter
    // ------------------------------------------------------------------

`ifdef AXI4_RESP_LFSR_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Advance the LFSR (right-shifting Fibonacci form) on every AR handshake.
    always_comb begin
        lfsr_d = lfsr_q;
        if (ar_hs) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // LFSR register, reseeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // The value present at the handshake edge sets this transaction's jitter.
    assign extra_lat = lfsr_q[2:0];
`else
    assign extra_lat = 3'd0;
`endif

    // Counter reload: the WAIT state lasts (LATENCY - 1 + extra) + 1 edges,
    // which puts the RESP entry exactly LATENCY + extra edges after the
    // handshake edge.
    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(extra_lat);

    // ------------------------------------------------------------------
    // FSM: next-state and datapath
    // ------------------------------------------------------------------

    // Next-state, counter and response-capture logic for the single
    // outstanding read.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;

        unique case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    addr_d  = araddr;
                    cnt_d   = cnt_load;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = rd_ok ? rd_word : 64'd0;
                    rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RESP: begin
                // rvalid is known high in this state, so rready alone
                // completes the beat.
                if (rready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered images of the next state, so
        // arready is low from the AR edge and high again from the R edge.
        arready_d = (state_d == S_IDLE);
        rvalid_d  = (state_d == S_RESP);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // FSM and output registers; reset drops any pending read immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= 2'b00;
            cnt_q     <= '0;
            addr_q    <= 64'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
        end
    end

    // Preload writes, accepted on any edge regardless of FSM state;
    // out-of-range writes are dropped.
    // NOTE: the RAM has no reset on purpose: contents survive rst, and a
    // resettable array would not map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (init_we && init_ok) begin
            mem[init_idx] <= init_data;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------

    // A pending R beat must hold its payload until it is accepted.
    a_r_stable : assert property (@(posedge clk) disable iff (rst)
        (rvalid_q && !rready) |=> (rvalid_q && $stable(rdata_q) && $stable(rresp_q)));

    // Only one transaction is in flight: never ready for AR while R is pending.
    a_one_outstanding : assert property (@(posedge clk) disable iff (rst)
        !(arready_q && rvalid_q));

endmodule
